dct2_quant: RTL and testbench

- Scalar quantizer directly downstream of the 2-D DCT2 toplevel.
- Consumes one 32-lane, 16-bit coefficient row per cycle whenever the transform asserts write.
- Applies VVC-style flat quantization (QP-indexed scale, rate-dependent shift, intra deadzone offset).
- Emits 16-bit signed levels row by row, with block-boundary and coded-block (nonzero) flags, toward the entropy-coding stage.

---
 rtl/dct2_quant_pkg.sv | 67 ++++++
 rtl/dct2_quant_if.sv | 24 ++
 rtl/dct2_quant_lane.sv | 64 ++++++
 rtl/dct2_quant.sv | 153 +++++++++++++++
 tb/tb_dct2_quant.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dct2_quant_pkg.sv
// Shared constants and arithmetic helpers for the DCT2 flat quantizer.
package dct_pkg;
  localparam int LANES     = 32;
  localparam int CW        = 16;
  localparam int BIT_DEPTH = 8;
  localparam int MAX_QP    = 51;
  localparam int ROW_W     = LANES * CW;

  typedef enum logic [1:0] {
    SZ_4  = 2'b00,
    SZ_8  = 2'b01,
    SZ_16 = 2'b10,
    SZ_32 = 2'b11
  } size_code_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_BLOCK = 1'b1
  } blk_state_e;

  localparam logic [14:0] QUANT_SCALE [6] = '{15'd26214, 15'd23302, 15'd20560,
                                              15'd18396, 15'd16384, 15'd14564};

  function automatic logic [5:0] clamp_qp(input logic [5:0] qp);
    if (qp > 6'(MAX_QP)) begin
      return 6'(MAX_QP);
    end else begin
      return qp;
    end
  endfunction

  function automatic logic [4:0] size_m1(input logic [1:0] n);
    case (n)
      SZ_4:    return 5'd3;
      SZ_8:    return 5'd7;
      SZ_16:   return 5'd15;
      SZ_32:   return 5'd31;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [14:0] quant_scale(input logic [5:0] qp);
    logic [2:0] m;
    m = 3'(qp % 6'd6);
    case (m)
      3'd0:    return QUANT_SCALE[0];
      3'd1:    return QUANT_SCALE[1];
      3'd2:    return QUANT_SCALE[2];
      3'd3:    return QUANT_SCALE[3];
      3'd4:    return QUANT_SCALE[4];
      3'd5:    return QUANT_SCALE[5];
      default: return QUANT_SCALE[0];
    endcase
  endfunction

  // Right shift S = 29 - BIT_DEPTH + qp/6 - log2(size); log2(size) = n + 2.
  function automatic logic [4:0] quant_shift(input logic [5:0] qp, input logic [1:0] n);
    logic [3:0] per;
    per = 4'(qp / 6'd6);
    return 5'(29 - BIT_DEPTH) + 5'(per) - 5'(n) - 5'd2;
  endfunction

  // Intra deadzone rounding offset, 171/512 of one output step.
  function automatic logic [25:0] quant_offset(input logic [4:0] shift);
    return 26'd171 << (shift - 5'd9);
  endfunction
endpackage

// File: rtl/dct2_quant_if.sv
// Coefficient-in / level-out bundle between transform, quantizer and entropy coder.
interface dct2_quant_if;
  import dct_pkg::*;

  logic [ROW_W-1:0] coef_in;
  logic             coef_valid;
  logic [1:0]       N;
  logic [5:0]       qp;
  logic [ROW_W-1:0] level_out;
  logic             out_valid;
  logic             out_last;
  logic [4:0]       row_idx;
  logic             block_nz;

  modport master (
    output coef_in, coef_valid, N, qp,
    input  level_out, out_valid, out_last, row_idx, block_nz
  );

  modport slave (
    input  coef_in, coef_valid, N, qp,
    output level_out, out_valid, out_last, row_idx, block_nz
  );
endinterface

// File: rtl/dct2_quant_lane.sv
// One coefficient lane: stage 1 takes |c| * scale, stage 2 rounds, shifts and restores sign.
module quant_lane
  import dct_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en1,
  input  logic [CW-1:0] i_coef,
  input  logic [14:0]   i_scale,
  input  logic          i_en2,
  input  logic          i_act,
  input  logic [4:0]    i_shift,
  output logic [CW-1:0] o_level,
  output logic          o_nz_next
);
  logic [CW-1:0] w_abs;
  logic [30:0]   w_prod;
  logic          r_sign;
  logic [30:0]   r_p;
  logic [35:0]   w_sum;
  logic [35:0]   w_shr;
  logic [14:0]   w_mag;
  logic [CW-1:0] w_level;
  logic [CW-1:0] r_level;
  logic          w_unused_hi;

  // Unsigned magnitude keeps -32768 representable as 32768.
  assign w_abs  = i_coef[CW-1] ? (~i_coef + 16'd1) : i_coef;
  assign w_prod = 31'(w_abs) * 31'(i_scale);

  // Stage 1: sign and product register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sign <= 1'b0;
      r_p    <= 31'd0;
    end else if (i_en1) begin
      r_sign <= i_coef[CW-1];
      r_p    <= w_prod;
    end else begin
      r_sign <= r_sign;
      r_p    <= r_p;
    end
  end

  assign w_sum       = 36'(r_p) + 36'(quant_offset(i_shift));
  assign w_shr       = w_sum >> i_shift;
  assign w_mag       = i_act ? w_shr[14:0] : 15'd0;
  assign w_level     = r_sign ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
  assign o_nz_next   = |w_mag;
  assign w_unused_hi = ^w_shr[35:15];

  // Stage 2: level register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= 16'd0;
    end else if (i_en2) begin
      r_level <= w_level;
    end else begin
      r_level <= r_level;
    end
  end

  assign o_level = r_level;
endmodule

// File: rtl/dct2_quant.sv
// Row-wise flat quantizer: block tracking, parameter latching, 2-stage lane array, nz flag.
module dct2_quant
  import dct_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  dct2_quant_if.slave  bus
);
  logic             w_acc;
  logic [1:0]       w_n_eff;
  logic [5:0]       w_qp_eff;
  logic [4:0]       w_szm1_eff;
  logic             w_last0;
  logic [14:0]      w_scale;
  blk_state_e       r_state;
  blk_state_e       w_state_next;
  logic [4:0]       r_cnt;
  logic [1:0]       r_blk_n;
  logic [5:0]       r_blk_qp;
  logic             r_v1;
  logic             r_last1;
  logic [4:0]       r_row1;
  logic [4:0]       r_shift1;
  logic [4:0]       r_szm1_1;
  logic             r_out_valid;
  logic             r_out_last;
  logic [4:0]       r_row_idx;
  logic             r_block_nz;
  logic             r_nz_acc;
  logic [LANES-1:0] w_lane_nz;
  logic             w_row_nz;
  logic [ROW_W-1:0] w_levels;

  // The first row of a block uses the live N/qp; later rows use the latched copies.
  assign w_acc      = bus.coef_valid;
  assign w_n_eff    = (r_state == ST_IDLE) ? bus.N : r_blk_n;
  assign w_qp_eff   = (r_state == ST_IDLE) ? clamp_qp(bus.qp) : r_blk_qp;
  assign w_szm1_eff = size_m1(w_n_eff);
  assign w_last0    = (r_cnt == w_szm1_eff);
  assign w_scale    = quant_scale(w_qp_eff);

  // Block state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Block state next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && !w_last0) w_state_next = ST_IN_BLOCK;
        else                   w_state_next = ST_IDLE;
      end
      ST_IN_BLOCK: begin
        if (w_acc && w_last0) w_state_next = ST_IDLE;
        else                  w_state_next = ST_IN_BLOCK;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Row counter and block parameter latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 5'd0;
      r_blk_n  <= 2'd0;
      r_blk_qp <= 6'd0;
    end else if (w_acc) begin
      r_cnt    <= w_last0 ? 5'd0 : (r_cnt + 5'd1);
      r_blk_n  <= w_n_eff;
      r_blk_qp <= w_qp_eff;
    end else begin
      r_cnt    <= r_cnt;
      r_blk_n  <= r_blk_n;
      r_blk_qp <= r_blk_qp;
    end
  end

  // Stage 1 side-band: row tag plus per-block shift and width for stage 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v1     <= 1'b0;
      r_last1  <= 1'b0;
      r_row1   <= 5'd0;
      r_shift1 <= 5'd0;
      r_szm1_1 <= 5'd0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_last1  <= w_last0;
        r_row1   <= r_cnt;
        r_shift1 <= quant_shift(w_qp_eff, w_n_eff);
        r_szm1_1 <= w_szm1_eff;
      end else begin
        r_last1  <= r_last1;
        r_row1   <= r_row1;
        r_shift1 <= r_shift1;
        r_szm1_1 <= r_szm1_1;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    quant_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_en1     (w_acc),
      .i_coef    (bus.coef_in[ROW_W-1-CW*gi -: CW]),
      .i_scale   (w_scale),
      .i_en2     (r_v1),
      .i_act     (5'(gi) <= r_szm1_1),
      .i_shift   (r_shift1),
      .o_level   (w_levels[ROW_W-1-CW*gi -: CW]),
      .o_nz_next (w_lane_nz[gi])
    );
  end

  assign w_row_nz = |w_lane_nz;

  // Stage 2 side-band and sticky nonzero accumulator; the last row's own nz is folded in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_row_idx   <= 5'd0;
      r_block_nz  <= 1'b0;
      r_nz_acc    <= 1'b0;
    end else begin
      r_out_valid <= r_v1;
      r_out_last  <= r_v1 & r_last1;
      if (r_v1) begin
        r_row_idx  <= r_row1;
        r_block_nz <= r_last1 & (r_nz_acc | w_row_nz);
        r_nz_acc   <= r_last1 ? 1'b0 : (r_nz_acc | w_row_nz);
      end else begin
        r_row_idx  <= r_row_idx;
        r_block_nz <= 1'b0;
        r_nz_acc   <= r_nz_acc;
      end
    end
  end

  assign bus.level_out = w_levels;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.row_idx   = r_row_idx;
  assign bus.block_nz  = r_block_nz;
endmodule

// File: tb/tb_dct2_quant.sv
// Self-checking bench for dct2_quant: vector table, directed sequences and a random run.
module tb_dct2_quant;
  import dct_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dct2_quant_if bus();
  dct2_quant dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [511:0] lv;
    bit           last;
    int           row;
    bit           nz;
    int           due;
  } exp_t;

  typedef struct {
    logic [1:0]  n;
    logic [5:0]  q;
    logic [15:0] c0, c1, c2, rest;
    bit          only_first;
    logic [15:0] e0, e1, e2;
    bit          enz;
  } vec_t;

  exp_t expq[$];
  vec_t tab[6];
  int checks = 0, failures = 0, cyc = 0;
  int m_cnt = 0, m_n = 0, m_q = 0;
  bit m_acc = 1'b0;
  int sc_tab[6] = '{26214, 23302, 20560, 18396, 16384, 14564};
  int n_valid, n_last, run, max_run, cap_last_row;
  logic [511:0] cap_row0;
  bit cap_nz;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] lane(input logic [511:0] r, input int i);
    return r[511-16*i -: 16];
  endfunction

  function automatic logic [511:0] mkrow(input int c0, input int c1, input int c2, input int rest);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[511-16*i -: 16] = 16'(rest);
    r[511 -: 16] = 16'(c0);
    r[495 -: 16] = 16'(c1);
    r[479 -: 16] = 16'(c2);
    return r;
  endfunction

  function automatic logic [511:0] rand_row();
    logic [511:0] r;
    logic [15:0] x;
    for (int i = 0; i < 32; i++) begin
      x = 16'($urandom);
      r[511-16*i -: 16] = 16'($signed(x) >>> $urandom_range(0, 15));
    end
    return r;
  endfunction

  function automatic vec_t mk(input int n, input int q, input int c0, input int c1, input int c2,
                              input int rest, input bit of, input int e0, input int e1,
                              input int e2, input bit enz);
    vec_t v;
    v.n = 2'(n); v.q = 6'(q);
    v.c0 = 16'(c0); v.c1 = 16'(c1); v.c2 = 16'(c2); v.rest = 16'(rest);
    v.only_first = of;
    v.e0 = 16'(e0); v.e1 = 16'(e1); v.e2 = 16'(e2); v.enz = enz;
    return v;
  endfunction

  // Reference: flat quantization straight from the arithmetic definition, per accepted row.
  task automatic model_accept(input logic [511:0] c, input int n, input int q);
    int size, sh, off, sc;
    longint v, a, m;
    logic [511:0] lv;
    bit nz, last;
    exp_t e;
    if (m_cnt == 0) begin
      m_n = n;
      m_q = (q > 51) ? 51 : q;
    end
    size = 4 << m_n;
    sc   = sc_tab[m_q % 6];
    sh   = 29 - 8 + m_q / 6 - (m_n + 2);
    off  = 171 << (sh - 9);
    nz   = 1'b0;
    lv   = '0;
    for (int i = 0; i < size; i++) begin
      v = longint'($signed(c[511-16*i -: 16]));
      a = (v < 0) ? -v : v;
      m = (a * sc + off) >> sh;
      lv[511-16*i -: 16] = 16'((v < 0) ? -m : m);
      if (m != 0) nz = 1'b1;
    end
    last   = (m_cnt == size - 1);
    e.lv   = lv;
    e.last = last;
    e.row  = m_cnt;
    e.nz   = m_acc | nz;
    e.due  = cyc + 1;
    expq.push_back(e);
    m_acc = last ? 1'b0 : (m_acc | nz);
    m_cnt = last ? 0 : m_cnt + 1;
  endtask

  task automatic check_out();
    exp_t e;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("out_valid", 512'(bus.out_valid), 512'(1'b1));
      chk("level_out", bus.level_out, e.lv);
      chk("row_idx", 512'(bus.row_idx), 512'(e.row));
      chk("out_last", 512'(bus.out_last), 512'(e.last));
      if (e.last) chk("block_nz", 512'(bus.block_nz), 512'(e.nz));
    end else begin
      chk("out_valid_idle", 512'(bus.out_valid), 512'(1'b0));
    end
    if (bus.out_valid) begin
      n_valid++;
      run++;
      if (run > max_run) max_run = run;
      if (bus.row_idx == 5'd0) cap_row0 = bus.level_out;
      if (bus.out_last) begin
        n_last++;
        cap_nz = bus.block_nz;
        cap_last_row = int'(bus.row_idx);
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic step(input bit v, input logic [511:0] c, input logic [1:0] n, input logic [5:0] q);
    bus.coef_valid = v;
    bus.coef_in    = c;
    bus.N          = n;
    bus.qp         = q;
    @(posedge clk);
    cyc++;
    if (v && reset) model_accept(c, int'(n), int'(q));
    @(negedge clk);
    check_out();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, 2'd0, 6'd0);
  endtask

  task automatic clr_stats();
    n_valid = 0; n_last = 0; run = 0; max_run = 0; cap_last_row = -1;
  endtask

  initial begin
    logic [511:0] row;
    int size;
    reset = 1'b0;
    bus.coef_valid = 1'b0; bus.coef_in = '0; bus.N = 2'd0; bus.qp = 6'd0;
    clr_stats();
    tab[0] = mk(0, 22, 1000, -1000, 100, 7, 1'b0, 4, -4, 0, 1'b1);
    tab[1] = mk(3, 0, 32767, -32768, 0, 0, 1'b1, 13106, -13107, 0, 1'b1);
    tab[2] = mk(1, 37, 0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
    tab[3] = mk(0, 63, 32767, -20000, 5000, 0, 1'b0, 4, -3, 1, 1'b1);
    tab[4] = mk(0, 51, 32767, -20000, 5000, 0, 1'b0, 4, -3, 1, 1'b1);
    tab[5] = mk(2, 4, 100, -8, 1, 3, 1'b0, 12, -1, 0, 1'b1);

    repeat (2) @(negedge clk);
    chk("rst_level_out", bus.level_out, '0);
    chk("rst_out_valid", 512'(bus.out_valid), 512'(1'b0));
    chk("rst_out_last", 512'(bus.out_last), 512'(1'b0));
    chk("rst_row_idx", 512'(bus.row_idx), 512'(5'd0));
    chk("rst_block_nz", 512'(bus.block_nz), 512'(1'b0));
    reset = 1'b1;
    idle(2);

    for (int k = 0; k < 6; k++) begin
      size = 4 << tab[k].n;
      for (int r = 0; r < size; r++) begin
        row = (r == 0 || !tab[k].only_first) ?
              mkrow(int'($signed(tab[k].c0)), int'($signed(tab[k].c1)),
                    int'($signed(tab[k].c2)), int'($signed(tab[k].rest))) : '0;
        step(1'b1, row, tab[k].n, tab[k].q);
      end
      idle(3);
      chk($sformatf("tab%0d_lane0", k), 512'(lane(cap_row0, 0)), 512'(tab[k].e0));
      chk($sformatf("tab%0d_lane1", k), 512'(lane(cap_row0, 1)), 512'(tab[k].e1));
      chk($sformatf("tab%0d_lane2", k), 512'(lane(cap_row0, 2)), 512'(tab[k].e2));
      chk($sformatf("tab%0d_block_nz", k), 512'(cap_nz), 512'(tab[k].enz));
    end

    // N/qp changed at row 5 of a size-16 block must not alter the block.
    clr_stats();
    for (int r = 0; r < 16; r++) begin
      if (r < 5) step(1'b1, rand_row(), 2'd2, 6'd10);
      else       step(1'b1, rand_row(), 2'd0, 6'd0);
    end
    idle(3);
    chk("midchg_last_row", 512'(cap_last_row), 512'(15));
    chk("midchg_n_last", 512'(n_last), 512'(1));

    // Two size-4 blocks back to back; the second is all zero.
    clr_stats();
    for (int r = 0; r < 8; r++) begin
      row = (r < 4) ? mkrow(20000, -300, 77, 5) : '0;
      step(1'b1, row, 2'd0, 6'd20);
    end
    idle(3);
    chk("b2b_n_valid", 512'(n_valid), 512'(8));
    chk("b2b_n_last", 512'(n_last), 512'(2));
    chk("b2b_max_run", 512'(max_run), 512'(8));
    chk("b2b_last_nz", 512'(cap_nz), 512'(1'b0));

    // Reset asserted while row 2 of a size-8 block is presented.
    step(1'b1, rand_row(), 2'd1, 6'd30);
    step(1'b1, rand_row(), 2'd1, 6'd30);
    bus.coef_valid = 1'b1; bus.coef_in = rand_row();
    reset = 1'b0;
    #1;
    chk("mid_rst_level_out", bus.level_out, '0);
    chk("mid_rst_out_valid", 512'(bus.out_valid), 512'(1'b0));
    chk("mid_rst_out_last", 512'(bus.out_last), 512'(1'b0));
    chk("mid_rst_row_idx", 512'(bus.row_idx), 512'(5'd0));
    chk("mid_rst_block_nz", 512'(bus.block_nz), 512'(1'b0));
    expq.delete(); m_cnt = 0; m_acc = 1'b0;
    @(negedge clk);
    idle(2);
    reset = 1'b1;
    clr_stats();
    for (int r = 0; r < 4; r++) step(1'b1, rand_row(), 2'd0, 6'd40);
    idle(3);
    chk("post_rst_n_valid", 512'(n_valid), 512'(4));
    chk("post_rst_last_row", 512'(cap_last_row), 512'(3));

    // Randomized traffic with gaps, random sizes and qp up to 63.
    for (int i = 0; i < 600; i++) begin
      row = ($urandom_range(0, 7) == 0) ? '0 : rand_row();
      step($urandom_range(0, 9) < 7, row, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
    end
    idle(3);
    chk("drain_empty", 512'(expq.size()), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
